// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the LSU instruction (i*) and data (d*) Wishbone
// classic master ports onto one shared bus (m_*). One port is granted per
// transaction. Its signals are forwarded to the shared bus, and ack/err are
// routed back only to the granted port.
// Ports: clk, rst (sync, active-high); i* instruction port; d* data port;
//   m_* shared bus; gnt_o current grant (00 none, 01 instruction, 10 data).
// Params: ROUND_ROBIN (1 alternate on contention, 0 data always wins);
//   TIMEOUT_CYCLES (present only when ARB_TIMEOUT_EN is defined).
// Optional feature: define ARB_TIMEOUT_EN to enable the no-ack timeout
//   counter and the HOLD state.
module wb_port_arbiter #(
  parameter int ROUND_ROBIN = 1
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr_i,
  input  logic [31:0] idat_i,
  input  logic [3:0]  isel_i,
  input  logic        icyc_i,
  input  logic        istb_i,
  output logic [31:0] idat_o,
  output logic        iack_o,
  output logic        ierr_o,
  input  logic [31:0] daddr_i,
  input  logic [31:0] ddat_i,
  input  logic [3:0]  dsel_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  output logic [31:0] ddat_o,
  output logic        dack_o,
  output logic        derr_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
`ifdef ARB_TIMEOUT_EN
    , ST_HOLD = 2'd3
`endif
  } state_t;

  state_t     r_state;
  logic       r_last_d;
  logic [1:0] r_gnt;

  logic w_ireq;
  logic w_dreq;
  logic w_pick_d;
  logic w_sel_i;
  logic w_sel_d;
  logic w_xcyc;
  logic w_to;

  assign w_ireq  = icyc_i & istb_i;
  assign w_dreq  = dcyc_i & dstb_i;
  assign w_sel_i = (r_state == ST_GNT_I);
  assign w_sel_d = (r_state == ST_GNT_D);

  // D wins unless I also requests under round robin and D was served last.
  assign w_pick_d = w_dreq &
                    (~w_ireq | (ROUND_ROBIN == 0) | ~r_last_d);

  // Cycle line of the port owning the bus; in HOLD, the timed-out one.
  assign w_xcyc = r_last_d ? dcyc_i : icyc_i;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] r_cnt;

  // Expiry fires only while the master still holds cyc; an ack or error
  // in the same cycle completes the transfer normally.
  assign w_to = (w_sel_i | w_sel_d) & w_xcyc &
                (r_cnt == CW'(TIMEOUT_CYCLES)) &
                ~m_ack_i & ~m_err_i;
`else
  assign w_to = 1'b0;
`endif

  assign idat_o = m_dat_i;
  assign ddat_o = m_dat_i;
  assign gnt_o  = r_gnt;

  always_comb begin
    m_adr_o = '0;
    m_dat_o = '0;
    m_sel_o = '0;
    m_we_o  = 1'b0;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    iack_o  = 1'b0;
    ierr_o  = 1'b0;
    dack_o  = 1'b0;
    derr_o  = 1'b0;
    if (w_sel_i) begin
      m_adr_o = iaddr_i;
      m_dat_o = idat_i;
      m_sel_o = isel_i;
      m_cyc_o = icyc_i & ~w_to;
      m_stb_o = istb_i & ~w_to;
      iack_o  = m_ack_i;
      ierr_o  = m_err_i | w_to;
    end else if (w_sel_d) begin
      m_adr_o = daddr_i;
      m_dat_o = ddat_i;
      m_sel_o = dsel_i;
      m_we_o  = dwe_i;
      m_cyc_o = dcyc_i & ~w_to;
      m_stb_o = dstb_i & ~w_to;
      dack_o  = m_ack_i;
      derr_o  = m_err_i | w_to;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last_d <= 1'b0;
      r_gnt    <= 2'b00;
`ifdef ARB_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_d) begin
            r_state  <= ST_GNT_D;
            r_last_d <= 1'b1;
            r_gnt    <= 2'b10;
          end else if (w_ireq) begin
            r_state  <= ST_GNT_I;
            r_last_d <= 1'b0;
            r_gnt    <= 2'b01;
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (!w_xcyc) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_to) begin
            r_state <= ST_HOLD;
            r_gnt   <= 2'b00;
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        ST_HOLD: begin
          if (!w_xcyc) r_state <= ST_IDLE;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
`ifdef ARB_TIMEOUT_EN
      if (!(w_sel_i | w_sel_d) || m_ack_i || m_err_i)
        r_cnt <= '0;
      else if (m_cyc_o)
        r_cnt <= r_cnt + CW'(1);
`endif
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors for wb_port_arbiter with
// hand-computed expectations; timeout case runs when ARB_TIMEOUT_EN is set.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr_i, idat_i, daddr_i, ddat_i, m_dat_i;
  logic [3:0]  isel_i, dsel_i;
  logic        icyc_i, istb_i, dwe_i, dcyc_i, dstb_i;
  logic        m_ack_i, m_err_i;
  logic [31:0] idat_o, ddat_o, m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic        iack_o, ierr_o, dack_o, derr_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic [1:0]  gnt_o;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .ROUND_ROBIN(1)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .iaddr_i(iaddr_i), .idat_i(idat_i), .isel_i(isel_i),
    .icyc_i(icyc_i), .istb_i(istb_i),
    .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
    .daddr_i(daddr_i), .ddat_i(ddat_i), .dsel_i(dsel_i),
    .dwe_i(dwe_i), .dcyc_i(dcyc_i), .dstb_i(dstb_i),
    .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .gnt_o(gnt_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    iaddr_i = '0; idat_i = '0; isel_i = '0;
    icyc_i = 1'b0; istb_i = 1'b0;
    daddr_i = '0; ddat_i = '0; dsel_i = '0;
    dwe_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0;
    m_dat_i = '0; m_ack_i = 1'b0; m_err_i = 1'b0;

    // reset, idle with address lines wiggling
    tick; tick;
    rst = 1'b0;
    iaddr_i = 32'h55; daddr_i = 32'h66; m_dat_i = 32'h77;
    smp;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_cyc", 32'({m_cyc_o, m_stb_o, m_we_o}), 32'h0);
    chk("rst_ack", 32'({iack_o, dack_o, ierr_o, derr_o}), 32'h0);
    chk("rst_adr", m_adr_o, 32'h0);
    chk("rst_bcast", idat_o, 32'h77);

    // instruction read 0x100, acked two cycles later
    tick;
    icyc_i = 1'b1; istb_i = 1'b1; iaddr_i = 32'h100; isel_i = 4'hF;
    smp;
    chk("i_lat_cyc", 32'(m_cyc_o), 32'h0);
    tick; smp;
    chk("i_cyc", 32'({m_cyc_o, m_stb_o}), 32'h3);
    chk("i_gnt", 32'(gnt_o), 32'h1);
    chk("i_adr", m_adr_o, 32'h100);
    chk("i_sel_we", 32'({m_sel_o, m_we_o}), 32'h1E);
    tick; smp;
    chk("i_wait_ack", 32'(iack_o), 32'h0);
    tick;
    m_ack_i = 1'b1; m_dat_i = 32'h33;
    smp;
    chk("i_ack", 32'({iack_o, dack_o, ierr_o}), 32'h4);
    chk("i_dat", idat_o, 32'h33);
    tick;
    m_ack_i = 1'b0; icyc_i = 1'b0; istb_i = 1'b0;
    smp;
    chk("i_drop_cyc", 32'(m_cyc_o), 32'h0);
    chk("i_drop_gnt", 32'(gnt_o), 32'h1);
    tick; smp;
    chk("i_rel_gnt", 32'(gnt_o), 32'h0);

    // contention, last grant was I: D first, then I after one idle cycle
    tick;
    icyc_i = 1'b1; istb_i = 1'b1; iaddr_i = 32'h104;
    dcyc_i = 1'b1; dstb_i = 1'b1; daddr_i = 32'h300;
    dwe_i = 1'b1; ddat_i = 32'h1234; dsel_i = 4'hF;
    tick; smp;
    chk("rr_gnt_d", 32'(gnt_o), 32'h2);
    chk("rr_d_adr", m_adr_o, 32'h300);
    chk("rr_d_we", 32'(m_we_o), 32'h1);
    chk("rr_d_dat", m_dat_o, 32'h1234);
    tick;
    m_ack_i = 1'b1;
    smp;
    chk("rr_d_ack", 32'({dack_o, iack_o}), 32'h2);
    tick;
    m_ack_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0; dwe_i = 1'b0;
    tick; smp;
    chk("rr_idle_gnt", 32'(gnt_o), 32'h0);
    chk("rr_idle_cyc", 32'(m_cyc_o), 32'h0);
    tick; smp;
    chk("rr_gnt_i", 32'(gnt_o), 32'h1);
    chk("rr_i_adr", m_adr_o, 32'h104);
    tick;
    m_ack_i = 1'b1;
    smp;
    chk("rr_i_ack", 32'({dack_o, iack_o}), 32'h1);
    tick;
    m_ack_i = 1'b0; icyc_i = 1'b0; istb_i = 1'b0;
    tick; smp;
    chk("rr_i_rel", 32'(gnt_o), 32'h0);

    // data write 0x200, sel 3, data 0xBEEF
    tick;
    dcyc_i = 1'b1; dstb_i = 1'b1; daddr_i = 32'h200;
    dsel_i = 4'h3; dwe_i = 1'b1; ddat_i = 32'hBEEF;
    tick; smp;
    chk("w_adr", m_adr_o, 32'h200);
    chk("w_sel", 32'(m_sel_o), 32'h3);
    chk("w_we", 32'(m_we_o), 32'h1);
    chk("w_dat", m_dat_o, 32'hBEEF);
    tick;
    m_ack_i = 1'b1;
    smp;
    chk("w_ack", 32'({dack_o, iack_o}), 32'h2);
    tick;
    m_ack_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0; dwe_i = 1'b0;
    tick; smp;
    chk("w_rel", 32'(gnt_o), 32'h0);

    // contention, last grant was D: I wins; error routed to I only
    tick;
    icyc_i = 1'b1; istb_i = 1'b1;
    dcyc_i = 1'b1; dstb_i = 1'b1;
    tick; smp;
    chk("rr2_gnt_i", 32'(gnt_o), 32'h1);
    tick;
    m_err_i = 1'b1;
    smp;
    chk("rr2_err", 32'({ierr_o, derr_o, iack_o}), 32'h4);
    tick;
    m_err_i = 1'b0;
    icyc_i = 1'b0; istb_i = 1'b0;
    dcyc_i = 1'b0; dstb_i = 1'b0;
    tick; smp;
    chk("rr2_rel", 32'(gnt_o), 32'h0);

    // reset while D is waiting; later ack must not reach dack_o
    tick;
    dcyc_i = 1'b1; dstb_i = 1'b1; daddr_i = 32'h400;
    tick; smp;
    chk("r_gnt_d", 32'({gnt_o, m_cyc_o}), 32'h5);
    tick;
    rst = 1'b1; dcyc_i = 1'b0; dstb_i = 1'b0;
    tick;
    rst = 1'b0; m_ack_i = 1'b1;
    smp;
    chk("r_mid_cyc", 32'(m_cyc_o), 32'h0);
    chk("r_mid_gnt", 32'(gnt_o), 32'h0);
    chk("r_late_ack", 32'({dack_o, iack_o}), 32'h0);
    tick;
    m_ack_i = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // I request never acked: error after four waiting cycles
    tick;
    icyc_i = 1'b1; istb_i = 1'b1; iaddr_i = 32'h500;
    tick;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("to_wait", 32'({m_cyc_o, ierr_o}), 32'h2);
      tick;
    end
    smp;
    chk("to_err", 32'({m_cyc_o, m_stb_o, ierr_o}), 32'h1);
    chk("to_derr", 32'(derr_o), 32'h0);
    tick; smp;
    chk("to_hold", 32'({gnt_o, m_cyc_o, ierr_o}), 32'h0);
    tick; smp;
    chk("to_hold2", 32'({gnt_o, m_cyc_o}), 32'h0);
    icyc_i = 1'b0; istb_i = 1'b0;
    tick; smp;
    chk("to_idle", 32'(gnt_o), 32'h0);
    tick;
    icyc_i = 1'b1; istb_i = 1'b1;
    tick; smp;
    chk("to_regrant", 32'(gnt_o), 32'h1);
    tick;
    icyc_i = 1'b0; istb_i = 1'b0;
    tick;
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
